wb_trace_fifo: RTL and testbench
================================

# wb_trace_fifo

Write-back trace capture buffer for the MIPS32 pipeline. It records every committed register write-back event (PC, destination register, data, cycle timestamp) into a parametrised-depth FIFO. The cosimulation bench drains the FIFO through a valid/ready port, so it no longer has to sample dozens of raw pipeline wires every cycle. It sits beside the top-level core, fed from the MEM/WB outputs (`reg_write_final`, `w_addr`, `w_data`, `pc_value_mem_wb`).

## Interface

One clock; reset is synchronous and active-high.

**Parameters**
- `DEPTH`, default 16: FIFO entries. Must be a power of two, ≥ 2.
- `DATA_W`, default 32: width of the write-back data and of the PC fields.
- `REG_W`, default 5: register address width.
- `TS_W`, default 16: timestamp counter width.
- `DROP_W`, default 16: dropped-event counter width.

**Ports**
- `clock` in 1: rising-edge clock.
- `reset` in 1: synchronous, active-high.
- `enable` in 1: capture enable. When 0, nothing is pushed.
- `filter_zero` in 1: when 1, write-backs to register 0 are not recorded.
- `wb_valid` in 1: write-back commit strobe (`reg_write_final`).
- `wb_pc` in DATA_W: PC of the committing instruction.
- `wb_addr` in REG_W: destination register.
- `wb_data` in DATA_W: value written.
- `clear_ovf` in 1: one-cycle pulse. Clears `overflow` and `drop_count`.
- `out_valid` out 1: FIFO head is valid.
- `out_ready` in 1: consumer accepts the head.
- `out_pc` out DATA_W: head entry field.
- `out_addr` out REG_W: head entry field.
- `out_data` out DATA_W: head entry field.
- `out_ts` out TS_W: head entry field.
- `count` out clog2(DEPTH)+1: current occupancy.
- `overflow` out 1: sticky flag, set on any dropped event.
- `drop_count` out DROP_W: saturating count of dropped events.

## Operation

- **Timestamp counter `ts`**
  - Free-running; increments every cycle.
  - Wraps from 2^TS_W−1 to 0.
  - Reset value 0.
  - An event is stamped with the value of `ts` in the cycle its `wb_valid` is sampled.
- **Capture condition:** `cap = enable & wb_valid & ~(filter_zero & (wb_addr == 0))`.
- **Pop condition:** `pop = out_valid & out_ready`.
- **Push condition:** `push = cap & (~full | pop)`.
  - When the FIFO is full, a simultaneous pop frees a slot, so the push is accepted.
- **Drop condition:** `drop = cap & full & ~pop`.
  - On a drop, `overflow` is set to 1.
  - `drop_count` increments and saturates at 2^DROP_W−1.
  - The FIFO contents are unchanged.
- **Storage and pointers**
  - Storage is a DEPTH-entry array of {pc, addr, data, ts}.
  - Write and read pointers are clog2(DEPTH) bits wide and wrap naturally.
  - `full = (count == DEPTH)`; `empty = (count == 0)`.
- **Count update:** `count` changes by +1 on push only, −1 on pop only, and 0 on both or neither.
- **Output port**
  - `out_*` present `mem[rd_ptr]` directly, with no extra register stage.
  - `out_valid = ~empty`.
  - While `out_valid` is 1, `out_*` are held stable until popped.
  - While `out_valid` is 0, `out_*` are don't-care.
- **There is no fall-through.** An event pushed into an empty FIFO is not visible in the same cycle.
- **`clear_ovf`**
  - Clears `overflow` and `drop_count` to 0 on the next edge.
  - If a drop occurs in the same cycle, the clear wins: `overflow` = 0 and `drop_count` = 0. That event is lost without being counted.
- **Reset**
  - Resets pointers, `count`, `ts`, `overflow` and `drop_count` to 0, so `out_valid` = 0.
  - Storage contents are not reset.
  - Reset asserted mid-operation discards all queued entries, and any push or pop in that cycle is ignored.

## Timing

- **Push latency:** an event captured at edge N appears with `out_valid` = 1 from just after edge N, i.e. visible in cycle N+1.
- **Pop:** takes effect at the edge where `out_valid & out_ready` is 1. The next entry, if any, is presented immediately after that edge.
- **Throughput:** one push and one pop per cycle, sustained.
- **Status outputs:** `count`, `overflow` and `drop_count` are registered and update at the same edge as the event that changes them.
- **Reset values:** `out_valid` 0, `count` 0, `overflow` 0, `drop_count` 0. `out_ts` reflects stale storage.

## Test plan

1. **Ordered drain.** After reset, with `enable`=1, `filter_zero`=0 and `out_ready`=0, drive `wb_valid` for 3 consecutive cycles with (pc, addr, data) = (0x00400000, 8, 5), (0x00400004, 9, 7), (0x00400008, 10, 12).
   - `count` reaches 3.
   - Then raise `out_ready`: entries pop in order with `out_ts` = 0, 1, 2, and `out_valid` drops after the third pop.
2. **Register-0 filter.** With `filter_zero`=1, a write-back to addr 0 followed by one to addr 4 results in `count`=1 and a head with `out_addr`=4. With `filter_zero`=0 the same stimulus gives `count`=2.
3. **Overflow.** With DEPTH=16 and `out_ready`=0, push 20 events.
   - `count`=16, `overflow`=1, `drop_count`=4.
   - The head is the first event; entry 16 is the sixteenth event.
   - Pulsing `clear_ovf` then gives `overflow`=0 and `drop_count`=0, with `count` still 16.
4. **Full with simultaneous push and pop.** With the FIFO full, assert `wb_valid` and `out_ready` in the same cycle.
   - `count` stays 16 and `drop_count` does not change.
   - The newest entry is stored at the tail and the old head is removed.
5. **Pointer wrap and timestamp wrap.** With TS_W=4, run streaming push and pop for 40 cycles, one event per cycle.
   - Popped data matches the pushed data, with no loss across pointer wrap.
   - `out_ts` sequence wraps 15 → 0.
6. **Reset mid-operation.** With 5 entries queued, assert `reset` for one cycle while `wb_valid`=1 and `out_ready`=1.
   - Next cycle: `count`=0, `out_valid`=0, `overflow`=0, `drop_count`=0.
   - The next captured event carries `out_ts` equal to the number of cycles since reset deasserted.

Source files
------------

// File: rtl/wb_trace_fifo.sv
// Write-back trace capture FIFO: stamps each committed register write-back
// with a free-running cycle counter and queues it for a valid/ready consumer.
module wb_trace_fifo #(
  parameter int DEPTH  = 16,
  parameter int DATA_W = 32,
  parameter int REG_W  = 5,
  parameter int TS_W   = 16,
  parameter int DROP_W = 16
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      enable,
  input  logic                      filter_zero,
  input  logic                      wb_valid,
  input  logic [DATA_W-1:0]         wb_pc,
  input  logic [REG_W-1:0]          wb_addr,
  input  logic [DATA_W-1:0]         wb_data,
  input  logic                      clear_ovf,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [DATA_W-1:0]         out_pc,
  output logic [REG_W-1:0]          out_addr,
  output logic [DATA_W-1:0]         out_data,
  output logic [TS_W-1:0]           out_ts,
  output logic [$clog2(DEPTH):0]    count,
  output logic                      overflow,
  output logic [DROP_W-1:0]         drop_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [DATA_W-1:0] mem_pc   [DEPTH];
  logic [REG_W-1:0]  mem_addr [DEPTH];
  logic [DATA_W-1:0] mem_data [DEPTH];
  logic [TS_W-1:0]   mem_ts   [DEPTH];

  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [TS_W-1:0] ts;
  logic full;
  logic empty;
  logic cap;
  logic pop;
  logic push;
  logic drop;

  // Capture/accept/drop decisions; a pop frees a slot for a same-cycle push when full.
  always_comb begin
    full  = (count == CW'(DEPTH));
    empty = (count == {CW{1'b0}});
    cap   = enable & wb_valid & ~(filter_zero & (wb_addr == {REG_W{1'b0}}));
    pop   = ~empty & out_ready;
    push  = cap & (~full | pop);
    drop  = cap & full & ~pop;
  end

  assign out_valid = ~empty;
  assign out_pc    = mem_pc[rd_ptr];
  assign out_addr  = mem_addr[rd_ptr];
  assign out_data  = mem_data[rd_ptr];
  assign out_ts    = mem_ts[rd_ptr];

  // Entry storage; deliberately not reset, only the pointers define validity.
  always_ff @(posedge clock) begin
    if (push && !reset) begin
      mem_pc[wr_ptr]   <= wb_pc;
      mem_addr[wr_ptr] <= wb_addr;
      mem_data[wr_ptr] <= wb_data;
      mem_ts[wr_ptr]   <= ts;
    end
  end

  // Pointers, occupancy and timestamp counter.
  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr <= {AW{1'b0}};
      rd_ptr <= {AW{1'b0}};
      count  <= {CW{1'b0}};
      ts     <= {TS_W{1'b0}};
    end else begin
      ts <= ts + TS_W'(1);
      if (push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Sticky overflow and saturating drop counter; a clear beats a same-cycle drop.
  always_ff @(posedge clock) begin
    if (reset) begin
      overflow   <= 1'b0;
      drop_count <= {DROP_W{1'b0}};
    end else if (clear_ovf) begin
      overflow   <= 1'b0;
      drop_count <= {DROP_W{1'b0}};
    end else if (drop) begin
      overflow <= 1'b1;
      if (drop_count != {DROP_W{1'b1}}) begin
        drop_count <= drop_count + DROP_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_wb_trace_fifo.sv
// Randomised + directed bench for wb_trace_fifo, checked every cycle against
// a queue-based reference model.
module tb_wb_trace_fifo;

  localparam int DEPTH    = 16;
  localparam int TS_W     = 4;
  localparam int DROP_W   = 4;
  localparam int DROP_MAX = 15;
  localparam int TS_MOD   = 16;

  typedef struct packed {
    logic [31:0] pc;
    logic [4:0]  addr;
    logic [31:0] data;
    logic [3:0]  ts;
  } ent_t;

  logic        clock = 1'b0;
  logic        reset, enable, filter_zero, wb_valid, clear_ovf, out_ready;
  logic [31:0] wb_pc, wb_data;
  logic [4:0]  wb_addr;
  logic        out_valid, overflow;
  logic [31:0] out_pc, out_data;
  logic [4:0]  out_addr;
  logic [3:0]  out_ts;
  logic [4:0]  count;
  logic [3:0]  drop_count;

  int checks = 0;
  int passed = 0;
  bit chk_on = 1'b0;

  ent_t m_q[$];
  int   m_ts  = 0;
  bit   m_ovf = 1'b0;
  int   m_dc  = 0;

  wb_trace_fifo #(.DEPTH(DEPTH), .DATA_W(32), .REG_W(5), .TS_W(TS_W), .DROP_W(DROP_W)) dut (
    .clock(clock), .reset(reset), .enable(enable), .filter_zero(filter_zero),
    .wb_valid(wb_valid), .wb_pc(wb_pc), .wb_addr(wb_addr), .wb_data(wb_data),
    .clear_ovf(clear_ovf), .out_valid(out_valid), .out_ready(out_ready),
    .out_pc(out_pc), .out_addr(out_addr), .out_data(out_data), .out_ts(out_ts),
    .count(count), .overflow(overflow), .drop_count(drop_count)
  );

  always #5 clock = ~clock;

  task automatic check(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // Reference model: the FIFO as a queue, updated from the inputs sampled at each edge.
  always @(posedge clock) begin
    bit cap, pop, full, drop;
    if (reset) begin
      m_q.delete();
      m_ts  = 0;
      m_ovf = 1'b0;
      m_dc  = 0;
    end else begin
      cap  = enable && wb_valid && !(filter_zero && wb_addr == 5'd0);
      pop  = (m_q.size() != 0) && out_ready;
      full = (m_q.size() == DEPTH);
      drop = cap && full && !pop;
      if (pop) void'(m_q.pop_front());
      if (cap && (!full || pop)) m_q.push_back('{wb_pc, wb_addr, wb_data, 4'(m_ts)});
      if (clear_ovf) begin
        m_ovf = 1'b0;
        m_dc  = 0;
      end else if (drop) begin
        m_ovf = 1'b1;
        if (m_dc < DROP_MAX) m_dc++;
      end
      m_ts = (m_ts + 1) % TS_MOD;
    end
  end

  // Compare every cycle on the falling edge.
  always @(negedge clock) begin
    if (chk_on) begin
      check("out_valid", 64'(out_valid), 64'(m_q.size() != 0));
      check("count", 64'(count), 64'(m_q.size()));
      check("overflow", 64'(overflow), 64'(m_ovf));
      check("drop_count", 64'(drop_count), 64'(m_dc));
      if (m_q.size() != 0) begin
        check("out_pc", 64'(out_pc), 64'(m_q[0].pc));
        check("out_addr", 64'(out_addr), 64'(m_q[0].addr));
        check("out_data", 64'(out_data), 64'(m_q[0].data));
        check("out_ts", 64'(out_ts), 64'(m_q[0].ts));
      end
    end
  end

  task automatic tick();
    @(posedge clock);
    #2;
  endtask

  task automatic ev(logic [31:0] pc, logic [4:0] addr, logic [31:0] data);
    wb_valid = 1'b1;
    wb_pc    = pc;
    wb_addr  = addr;
    wb_data  = data;
    tick();
    wb_valid = 1'b0;
  endtask

  task automatic do_reset();
    reset    = 1'b1;
    wb_valid = 1'b0;
    tick();
    reset    = 1'b0;
  endtask

  initial begin
    int wraps;
    int prev_ts;
    logic [31:0] t1_data [3];
    t1_data[0] = 32'd5;
    t1_data[1] = 32'd7;
    t1_data[2] = 32'd12;
    reset = 1'b1; enable = 1'b0; filter_zero = 1'b0; wb_valid = 1'b0;
    clear_ovf = 1'b0; out_ready = 1'b0;
    wb_pc = 32'd0; wb_addr = 5'd0; wb_data = 32'd0;
    tick(); tick();
    chk_on = 1'b1;
    check("reset_valid", 64'(out_valid), 64'd0);
    check("reset_count", 64'(count), 64'd0);

    // Ordered drain
    reset = 1'b0; enable = 1'b1;
    for (int i = 0; i < 3; i++) ev(32'h0040_0000 + 32'(4 * i), 5'(8 + i), t1_data[i]);
    check("t1_count", 64'(count), 64'd3);
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      check("t1_ts", 64'(out_ts), 64'(i));
      check("t1_data", 64'(out_data), 64'(t1_data[i]));
      tick();
    end
    check("t1_empty", 64'(out_valid), 64'd0);
    out_ready = 1'b0;

    // Register-0 filter
    do_reset();
    filter_zero = 1'b1;
    ev(32'h100, 5'd0, 32'h11);
    ev(32'h104, 5'd4, 32'h22);
    check("t2_filt_count", 64'(count), 64'd1);
    check("t2_filt_addr", 64'(out_addr), 64'd4);
    do_reset();
    filter_zero = 1'b0;
    ev(32'h100, 5'd0, 32'h11);
    ev(32'h104, 5'd4, 32'h22);
    check("t2_nofilt_count", 64'(count), 64'd2);

    // Overflow, clear, saturation
    do_reset();
    for (int i = 0; i < 20; i++) ev(32'(4 * i), 5'(1 + i % 31), 32'hA000 + 32'(i));
    check("t3_count", 64'(count), 64'd16);
    check("t3_ovf", 64'(overflow), 64'd1);
    check("t3_drops", 64'(drop_count), 64'd4);
    check("t3_head", 64'(out_data), 64'hA000);
    clear_ovf = 1'b1; tick(); clear_ovf = 1'b0;
    check("t3_clr_ovf", 64'(overflow), 64'd0);
    check("t3_clr_drops", 64'(drop_count), 64'd0);
    check("t3_clr_count", 64'(count), 64'd16);
    for (int i = 0; i < 20; i++) ev(32'hF00, 5'd3, 32'hDEAD);
    check("t3_sat", 64'(drop_count), 64'd15);

    // Full with simultaneous push and pop
    out_ready = 1'b1;
    ev(32'hC0, 5'd7, 32'hBEEF);
    out_ready = 1'b0;
    check("t4_count", 64'(count), 64'd16);
    check("t4_drops", 64'(drop_count), 64'd15);
    check("t4_head", 64'(out_data), 64'hA001);

    // Streaming across pointer and timestamp wrap
    do_reset();
    out_ready = 1'b1;
    wraps = 0;
    prev_ts = -1;
    for (int i = 0; i < 40; i++) begin
      if (out_valid) begin
        if (prev_ts == 15 && out_ts == 4'd0) wraps++;
        prev_ts = int'(out_ts);
      end
      ev($urandom, 5'($urandom_range(1, 31)), $urandom);
    end
    check("t5_ts_wraps", 64'(wraps), 64'd2);
    tick();
    out_ready = 1'b0;

    // Reset mid-operation
    do_reset();
    for (int i = 0; i < 5; i++) ev(32'(i), 5'd9, 32'(i));
    check("t6_pre_count", 64'(count), 64'd5);
    reset = 1'b1; wb_valid = 1'b1; out_ready = 1'b1;
    tick();
    reset = 1'b0; wb_valid = 1'b0; out_ready = 1'b0;
    check("t6_count", 64'(count), 64'd0);
    check("t6_valid", 64'(out_valid), 64'd0);
    check("t6_ovf", 64'(overflow), 64'd0);
    check("t6_drops", 64'(drop_count), 64'd0);
    tick(); tick(); tick();
    ev(32'h55, 5'd2, 32'h66);
    check("t6_ts", 64'(out_ts), 64'd3);

    // Random soak
    for (int i = 0; i < 800; i++) begin
      reset       = ($urandom_range(0, 99) == 0);
      enable      = ($urandom_range(0, 9) != 0);
      filter_zero = $urandom_range(0, 1);
      wb_valid    = ($urandom_range(0, 3) != 0);
      wb_pc       = $urandom;
      wb_addr     = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom);
      wb_data     = $urandom;
      out_ready   = ($urandom_range(0, 2) == 0);
      clear_ovf   = ($urandom_range(0, 49) == 0);
      tick();
    end
    reset = 1'b0; wb_valid = 1'b0; clear_ovf = 1'b0;
    tick();
    chk_on = 1'b0;
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
